// File: rtl/traffic_pkg.sv
// Shared phase codes, pedestrian-light codes and crosswalk/left-turn service
// tables used by the intersection controller and its light decoders.
package traffic_pkg;

  localparam logic [4:0] n_s     = 5'd0;
  localparam logic [4:0] e_w     = 5'd1;
  localparam logic [4:0] n_s_y   = 5'd2;
  localparam logic [4:0] e_w_y   = 5'd3;
  localparam logic [4:0] n_nl    = 5'd4;
  localparam logic [4:0] n_nl_y  = 5'd5;
  localparam logic [4:0] s_sl    = 5'd6;
  localparam logic [4:0] s_sl_y  = 5'd7;
  localparam logic [4:0] w_wl    = 5'd8;
  localparam logic [4:0] w_wl_y  = 5'd9;
  localparam logic [4:0] e_el    = 5'd10;
  localparam logic [4:0] e_el_y  = 5'd11;
  localparam logic [4:0] sl_nl   = 5'd12;
  localparam logic [4:0] sl_nl_y = 5'd13;
  localparam logic [4:0] el_wl   = 5'd14;
  localparam logic [4:0] el_wl_y = 5'd15;

  localparam logic [1:0] off         = 2'd0;
  localparam logic [1:0] walking_man = 2'd1;
  localparam logic [1:0] red_hand    = 2'd2;

  // Crosswalks {N,S,E,W} whose pedestrians cross while this green runs.
  function automatic logic [3:0] ped_served(input logic [4:0] phase);
    case (phase)
      n_s:     ped_served = 4'b0011;
      e_w:     ped_served = 4'b1100;
      n_nl:    ped_served = 4'b0001;
      s_sl:    ped_served = 4'b0010;
      w_wl:    ped_served = 4'b0100;
      e_el:    ped_served = 4'b1000;
      default: ped_served = 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] left_served(input logic [4:0] phase);
    case (phase)
      n_nl:    left_served = 4'b1000;
      s_sl:    left_served = 4'b0100;
      e_el:    left_served = 4'b0010;
      w_wl:    left_served = 4'b0001;
      sl_nl:   left_served = 4'b1100;
      el_wl:   left_served = 4'b0011;
      default: left_served = 4'b0000;
    endcase
  endfunction

  function automatic logic is_yellow(input logic [4:0] phase);
    case (phase)
      n_s_y, e_w_y, n_nl_y, s_sl_y, w_wl_y, e_el_y, sl_nl_y, el_wl_y: is_yellow = 1'b1;
      default: is_yellow = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_controller_phase_timer.sv
// Loadable 8-bit down counter advanced by the tick enable; load has priority
// and the counter parks at zero until the next load.
module phase_timer #(
  parameter logic [7:0] RST_VAL = 8'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] count,
  output logic       zero
);

  logic [7:0] count_q;

  // Down-count on tick, reload on phase change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= RST_VAL;
    end else if (load) begin
      count_q <= load_val;
    end else if (tick && (count_q != 8'd0)) begin
      count_q <= count_q - 8'd1;
    end else begin
      count_q <= count_q;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == 8'd0);

endmodule

// File: rtl/traffic_phase_controller.sv
// Intersection phase sequencer: through greens, yellows and demand-driven
// left-turn phases, with latched requests and pedestrian green extension.
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int GREEN_TICKS  = 10,
  parameter int LEFT_TICKS   = 6,
  parameter int YELLOW_TICKS = 3,
  parameter int PED_EXTRA    = 4
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       tick,
  input  logic       lsn,
  input  logic       lss,
  input  logic       lse,
  input  logic       lsw,
  input  logic       psn,
  input  logic       pss,
  input  logic       pse,
  input  logic       psw,
  output logic [4:0] state1,
  output logic [7:0] timer,
  output logic       phase_change,
  output logic [7:0] demand
);

  localparam logic [7:0] TIMER_RST = 8'(GREEN_TICKS - 1);

  logic [4:0]  state_q;
  logic [4:0]  state_d;
  logic        phase_change_q;
  logic [7:0]  demand_q;
  logic [7:0]  demand_d;
  logic [7:0]  timer_s;
  logic        zero_s;
  logic        illegal_s;
  logic        advance_s;
  logic [31:0] base_s;
  logic [31:0] dur_s;
  logic [7:0]  load_val_s;
  logic [7:0]  set_s;
  logic [7:0]  clr_s;

  assign illegal_s = (state_q > 5'd15);
  assign advance_s = illegal_s | (tick & zero_s);

  // Next phase; the deciding yellows read left demand latched before this edge.
  always_comb begin
    state_d = n_s;
    case (state_q)
      n_s:     state_d = n_s_y;
      e_w:     state_d = e_w_y;
      n_nl:    state_d = n_nl_y;
      s_sl:    state_d = s_sl_y;
      w_wl:    state_d = w_wl_y;
      e_el:    state_d = e_el_y;
      sl_nl:   state_d = sl_nl_y;
      el_wl:   state_d = el_wl_y;
      n_s_y: begin
        case (demand_q[1:0])
          2'b11:   state_d = el_wl;
          2'b10:   state_d = e_el;
          2'b01:   state_d = w_wl;
          default: state_d = e_w;
        endcase
      end
      e_w_y: begin
        case (demand_q[3:2])
          2'b11:   state_d = sl_nl;
          2'b10:   state_d = n_nl;
          2'b01:   state_d = s_sl;
          default: state_d = n_s;
        endcase
      end
      el_wl_y, e_el_y, w_wl_y:   state_d = e_w;
      sl_nl_y, n_nl_y, s_sl_y:   state_d = n_s;
      default:                   state_d = n_s;
    endcase
  end

  // Duration of the phase being entered, extended for a waiting pedestrian.
  always_comb begin
    if (is_yellow(state_d)) begin
      base_s = 32'(YELLOW_TICKS);
    end else if ((state_d == n_s) || (state_d == e_w)) begin
      base_s = 32'(GREEN_TICKS);
    end else begin
      base_s = 32'(LEFT_TICKS);
    end
    if ((ped_served(state_d) & demand_q[7:4]) != 4'b0000) begin
      dur_s = base_s + 32'(PED_EXTRA);
    end else begin
      dur_s = base_s;
    end
    if (dur_s > 32'd255) begin
      load_val_s = 8'd254;
    end else begin
      load_val_s = 8'(dur_s - 32'd1);
    end
  end

  // Requests set every cycle; entering a serving green clears them and wins.
  always_comb begin
    set_s = {psn, pss, pse, psw, lsn, lss, lse, lsw};
    if (advance_s) begin
      clr_s = {ped_served(state_d), left_served(state_d)};
    end else begin
      clr_s = 8'h00;
    end
    demand_d = (demand_q | set_s) & ~clr_s;
  end

  // Phase register, change pulse and request latches.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q        <= n_s;
      phase_change_q <= 1'b0;
      demand_q       <= 8'h00;
    end else begin
      demand_q       <= demand_d;
      phase_change_q <= advance_s;
      if (advance_s) begin
        state_q <= state_d;
      end else begin
        state_q <= state_q;
      end
    end
  end

  phase_timer #(
    .RST_VAL (TIMER_RST)
  ) u_phase_timer (
    .clk      (CLK),
    .rst      (rst),
    .tick     (tick),
    .load     (advance_s),
    .load_val (load_val_s),
    .count    (timer_s),
    .zero     (zero_s)
  );

  assign state1       = state_q;
  assign timer        = timer_s;
  assign phase_change = phase_change_q;
  assign demand       = demand_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller: phase sequence, left-turn and
// pedestrian demand handling, async reset and tick gating.
module tb_traffic_phase_controller;
  import traffic_pkg::*;

  logic       CLK = 1'b0;
  logic       rst;
  logic       tick;
  logic       lsn, lss, lse, lsw;
  logic       psn, pss, pse, psw;
  logic [4:0] state1;
  logic [7:0] timer;
  logic       phase_change;
  logic [7:0] demand;

  int total = 0;
  int bad   = 0;

  traffic_phase_controller dut (
    .CLK          (CLK),
    .rst          (rst),
    .tick         (tick),
    .lsn          (lsn),
    .lss          (lss),
    .lse          (lse),
    .lsw          (lsw),
    .psn          (psn),
    .pss          (pss),
    .pse          (pse),
    .psw          (psw),
    .state1       (state1),
    .timer        (timer),
    .phase_change (phase_change),
    .demand       (demand)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic drive(input logic [7:0] v);
    {psn, pss, pse, psw, lsn, lss, lse, lsw} = v;
  endtask

  // Called at the first sample of a phase; leaves the bench at the next phase entry.
  task automatic run_phase(input string tag, input logic [4:0] st, input int dur,
                           input logic pc, input logic [7:0] dem_in,
                           input logic [7:0] pulse, input logic [7:0] dem_out);
    chk({tag, ".state"}, {3'b000, state1}, {3'b000, st});
    chk({tag, ".timer"}, timer, 8'(dur - 1));
    chk({tag, ".pc"}, {7'd0, phase_change}, {7'd0, pc});
    chk({tag, ".dem_in"}, demand, dem_in);
    drive(pulse);
    for (int i = 0; i < dur - 1; i++) begin
      cyc();
      drive(8'h00);
    end
    chk({tag, ".state_end"}, {3'b000, state1}, {3'b000, st});
    chk({tag, ".timer_end"}, timer, 8'd0);
    chk({tag, ".pc_end"}, {7'd0, phase_change}, 8'd0);
    chk({tag, ".dem_out"}, demand, dem_out);
    cyc();
  endtask

  initial begin
    rst  = 1'b1;
    tick = 1'b1;
    drive(8'h00);
    cyc();
    chk("rst.state", {3'b000, state1}, {3'b000, n_s});
    chk("rst.timer", timer, 8'd9);
    chk("rst.pc", {7'd0, phase_change}, 8'd0);
    chk("rst.demand", demand, 8'h00);
    cyc();
    rst = 1'b0;

    // plain cycle, no demand
    run_phase("p1_ns",   n_s,   10, 1'b0, 8'h00, 8'h00, 8'h00);
    run_phase("p1_nsy",  n_s_y,  3, 1'b1, 8'h00, 8'h00, 8'h00);
    run_phase("p1_ew",   e_w,   10, 1'b1, 8'h00, 8'h00, 8'h00);
    run_phase("p1_ewy",  e_w_y,  3, 1'b1, 8'h00, 8'h00, 8'h00);
    run_phase("p1_ns2",  n_s,   10, 1'b1, 8'h00, 8'h00, 8'h00);
    run_phase("p1_nsy2", n_s_y,  3, 1'b1, 8'h00, 8'h00, 8'h00);

    // east left pulse during e_w
    run_phase("p2_ew",   e_w,   10, 1'b1, 8'h00, 8'h02, 8'h02);
    run_phase("p2_ewy",  e_w_y,  3, 1'b1, 8'h02, 8'h00, 8'h02);
    run_phase("p2_ns",   n_s,   10, 1'b1, 8'h02, 8'h00, 8'h02);
    run_phase("p2_nsy",  n_s_y,  3, 1'b1, 8'h02, 8'h00, 8'h02);
    run_phase("p2_eel",  e_el,   6, 1'b1, 8'h00, 8'h00, 8'h00);
    run_phase("p2_eely", e_el_y, 3, 1'b1, 8'h00, 8'h00, 8'h00);
    run_phase("p2_ew2",  e_w,   10, 1'b1, 8'h00, 8'h00, 8'h00);
    run_phase("p2_ewy2", e_w_y,  3, 1'b1, 8'h00, 8'h00, 8'h00);

    // north and south left pulses during n_s
    run_phase("p3_ns",   n_s,     10, 1'b1, 8'h00, 8'h0C, 8'h0C);
    run_phase("p3_nsy",  n_s_y,    3, 1'b1, 8'h0C, 8'h00, 8'h0C);
    run_phase("p3_ew",   e_w,     10, 1'b1, 8'h0C, 8'h00, 8'h0C);
    run_phase("p3_ewy",  e_w_y,    3, 1'b1, 8'h0C, 8'h00, 8'h0C);
    run_phase("p3_slnl", sl_nl,    6, 1'b1, 8'h00, 8'h00, 8'h00);
    run_phase("p3_slny", sl_nl_y,  3, 1'b1, 8'h00, 8'h00, 8'h00);
    run_phase("p3_ns2",  n_s,     10, 1'b1, 8'h00, 8'h00, 8'h00);
    run_phase("p3_nsy2", n_s_y,    3, 1'b1, 8'h00, 8'h00, 8'h00);

    // west pedestrian during e_w extends next n_s
    run_phase("p4_ew",   e_w,   10, 1'b1, 8'h00, 8'h10, 8'h10);
    run_phase("p4_ewy",  e_w_y,  3, 1'b1, 8'h10, 8'h00, 8'h10);
    run_phase("p4_ns",   n_s,   14, 1'b1, 8'h00, 8'h00, 8'h00);
    run_phase("p4_nsy",  n_s_y,  3, 1'b1, 8'h00, 8'h00, 8'h00);

    // async reset mid e_w_y
    run_phase("p5_ew",   e_w,   10, 1'b1, 8'h00, 8'h20, 8'h20);
    chk("p5.state_y", {3'b000, state1}, {3'b000, e_w_y});
    cyc();
    chk("p5.timer1", timer, 8'd1);
    chk("p5.dem_pre", demand, 8'h20);
    rst = 1'b1;
    #1;
    chk("p5.state", {3'b000, state1}, {3'b000, n_s});
    chk("p5.timer", timer, 8'd9);
    chk("p5.demand", demand, 8'h00);
    chk("p5.pc", {7'd0, phase_change}, 8'd0);
    cyc();
    cyc();
    rst = 1'b0;

    // tick gated low: hold state/timer, still latch a request
    cyc();
    cyc();
    cyc();
    chk("p6.timer_pre", timer, 8'd6);
    tick = 1'b0;
    drive(8'h40);
    cyc();
    drive(8'h00);
    repeat (49) cyc();
    chk("p6.state", {3'b000, state1}, {3'b000, n_s});
    chk("p6.timer", timer, 8'd6);
    chk("p6.demand", demand, 8'h40);
    chk("p6.pc", {7'd0, phase_change}, 8'd0);
    tick = 1'b1;
    repeat (6) cyc();
    chk("p6.timer0", timer, 8'd0);
    cyc();
    run_phase("p6_nsy", n_s_y,  3, 1'b1, 8'h40, 8'h00, 8'h40);
    run_phase("p6_ew",  e_w,   14, 1'b1, 8'h00, 8'h00, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
